// File: rtl/id_stage_pipe.sv
// id_stage_pipe: registered instruction-decode stage.
// Splits each accepted instruction into opcode/register/immediate fields and
// attaches a 2-bit branch prediction from a per-PC history table that the
// execute stage trains through the update port.
module id_stage_pipe #(
  parameter int INSTR_W   = 19,
  parameter int OPC_W     = 5,
  parameter int REG_W     = 3,
  parameter int IMM_W     = 15,
  parameter int PC_W      = 16,
  parameter int BHT_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [PC_W-1:0]    pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   opcode,
  output logic [REG_W-1:0]   rd,
  output logic [REG_W-1:0]   rs1,
  output logic [REG_W-1:0]   rs2,
  output logic [IMM_W-1:0]   immediate,
  output logic [PC_W-1:0]    pc_out,
  output logic               is_branch,
  output logic [1:0]         prediction,
  output logic               pred_taken,
  input  logic               upd_valid,
  input  logic [PC_W-1:0]    upd_pc,
  input  logic               upd_taken
);

  localparam int IDX_W   = $clog2(BHT_DEPTH);
  localparam int RD_MSB  = INSTR_W - OPC_W - 1;
  localparam int RS1_MSB = RD_MSB - REG_W;
  localparam int RS2_MSB = RS1_MSB - REG_W;

  localparam logic [OPC_W-1:0] OPC_BR_A = OPC_W'(5'b01010);
  localparam logic [OPC_W-1:0] OPC_BR_B = OPC_W'(5'b01011);
  localparam logic [OPC_W-1:0] OPC_BR_C = OPC_W'(5'b01100);

  // Output bundle registers and their next-state values.
  logic               valid_q,     valid_d;
  logic [OPC_W-1:0]   opcode_q,    opcode_d;
  logic [REG_W-1:0]   rd_q,        rd_d;
  logic [REG_W-1:0]   rs1_q,       rs1_d;
  logic [REG_W-1:0]   rs2_q,       rs2_d;
  logic [IMM_W-1:0]   imm_q,       imm_d;
  logic [PC_W-1:0]    pc_q,        pc_d;
  logic               is_branch_q, is_branch_d;
  logic [1:0]         pred_q,      pred_d;

  // Branch history table: one saturating 2-bit counter per index.
  logic [1:0]         bht_q [BHT_DEPTH];

  logic [IDX_W-1:0]   look_idx;
  logic [IDX_W-1:0]   upd_idx;
  logic [1:0]         upd_cnt;
  logic [1:0]         upd_next;
  logic [1:0]         look_cnt;
  logic [OPC_W-1:0]   dec_opcode;
  logic               dec_is_branch;
  logic               accept;

  // Only the low PC bits index the table; the rest alias by design.
  logic               upd_pc_unused;
  assign upd_pc_unused = ^upd_pc[PC_W-1:IDX_W];

  assign look_idx      = pc[IDX_W-1:0];
  assign upd_idx       = upd_pc[IDX_W-1:0];
  assign in_ready      = ~valid_q | out_ready;
  assign accept        = in_valid & in_ready & ~flush;
  assign dec_opcode    = instruction[INSTR_W-1 -: OPC_W];
  assign dec_is_branch = (dec_opcode == OPC_BR_A) || (dec_opcode == OPC_BR_B) ||
                         (dec_opcode == OPC_BR_C);

  // Saturating step of the counter being trained, and lookup with same-cycle bypass.
  always_comb begin
    // NOTE: every variable assigned here gets a value on every path first, so no latch is inferred.
    upd_cnt  = bht_q[upd_idx];
    upd_next = upd_cnt;
    if (upd_taken && (upd_cnt != 2'b11)) begin
      upd_next = upd_cnt + 2'b01;
    end else if (!upd_taken && (upd_cnt != 2'b00)) begin
      upd_next = upd_cnt - 2'b01;
    end
    look_cnt = (upd_valid && (upd_idx == look_idx)) ? upd_next : bht_q[look_idx];
  end

  // Next bundle: flush kills, accept loads, a consumed bundle drains, otherwise hold.
  always_comb begin
    valid_d     = valid_q;
    opcode_d    = opcode_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    is_branch_d = is_branch_q;
    pred_d      = pred_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d     = 1'b1;
      opcode_d    = dec_opcode;
      rd_d        = instruction[RD_MSB  -: REG_W];
      rs1_d       = instruction[RS1_MSB -: REG_W];
      rs2_d       = instruction[RS2_MSB -: REG_W];
      imm_d       = instruction[IMM_W-1:0];
      pc_d        = pc;
      is_branch_d = dec_is_branch;
      pred_d      = dec_is_branch ? look_cnt : 2'b00;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output bundle register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      valid_q     <= 1'b0;
      opcode_q    <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      is_branch_q <= 1'b0;
      pred_q      <= 2'b00;
    end else begin
      valid_q     <= valid_d;
      opcode_q    <= opcode_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      is_branch_q <= is_branch_d;
      pred_q      <= pred_d;
    end
  end

  // History table training; reset wins, so an update in the reset cycle is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every entry is reset to weakly-taken, which keeps the table in resettable flops rather than a RAM.
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= 2'b10;
      end
    end else if (upd_valid) begin
      bht_q[upd_idx] <= upd_next;
    end
  end

  assign out_valid  = valid_q;
  assign opcode     = opcode_q;
  assign rd         = rd_q;
  assign rs1        = rs1_q;
  assign rs2        = rs2_q;
  assign immediate  = imm_q;
  assign pc_out     = pc_q;
  assign is_branch  = is_branch_q;
  assign prediction = pred_q;
  assign pred_taken = is_branch_q & pred_q[1];

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: self-checking bench for id_stage_pipe (default parameters).
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [18:0] instruction;
  logic [15:0] pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  opcode;
  logic [2:0]  rd, rs1, rs2;
  logic [14:0] immediate;
  logic [15:0] pc_out;
  logic        is_branch;
  logic [1:0]  prediction;
  logic        pred_taken;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic        upd_taken;

  int total = 0;
  int bad   = 0;

  localparam logic [18:0] BR_INSTR = 19'b01010_000_000_000_00000;
  localparam logic [18:0] NB_INSTR = 19'b00001_000_000_000_00000;

  typedef struct {
    logic [18:0] instr;
    logic [15:0] pc;
    logic [4:0]  opc;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [14:0] imm;
    logic        br;
    logic [1:0]  pred;
  } vec_t;

  vec_t vecs [6];

  id_stage_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc(pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .immediate(immediate), .pc_out(pc_out), .is_branch(is_branch),
    .prediction(prediction), .pred_taken(pred_taken), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_taken(upd_taken)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    flush       = 1'b0;
    upd_valid   = 1'b0;
    upd_taken   = 1'b0;
    upd_pc      = '0;
    out_ready   = 1'b1;
    instruction = '0;
    pc          = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic upd_one(input logic [15:0] p, input logic t);
    upd_valid = 1'b1;
    upd_pc    = p;
    upd_taken = t;
    tick();
    upd_valid = 1'b0;
  endtask

  // Fetch one instruction with out_ready high and check the prediction it carries.
  task automatic fetch_one(input string nm, input logic [18:0] ins, input logic [15:0] p,
                           input logic [1:0] exp_pred);
    in_valid    = 1'b1;
    instruction = ins;
    pc          = p;
    tick();
    in_valid = 1'b0;
    check({nm, "_valid"}, out_valid, 1);
    check({nm, "_pc"}, pc_out, p);
    check({nm, "_pred"}, prediction, exp_pred);
    check({nm, "_taken"}, pred_taken, exp_pred[1]);
  endtask

  task automatic check_vec(input string nm, input vec_t v);
    check({nm, "_valid"}, out_valid, 1);
    check({nm, "_opc"}, opcode, v.opc);
    check({nm, "_rd"}, rd, v.rd);
    check({nm, "_rs1"}, rs1, v.rs1);
    check({nm, "_rs2"}, rs2, v.rs2);
    check({nm, "_imm"}, immediate, v.imm);
    check({nm, "_pc"}, pc_out, v.pc);
    check({nm, "_br"}, is_branch, v.br);
    check({nm, "_pred"}, prediction, v.pred);
    check({nm, "_ptaken"}, pred_taken, v.br & v.pred[1]);
  endtask

  initial begin
    int   got [$];
    int   sent;
    logic hs;
    logic [15:0] snap_pc;
    logic [4:0]  snap_opc;
    int   m_bht [16];
    bit   m_valid, m_br;
    int   m_opc, m_rd, m_rs1, m_rs2, m_imm, m_pc, m_pred;

    // Hand-decoded vectors; after reset every branch predicts weakly taken (2).
    vecs[0] = '{19'b01010_011_010_001_00000, 16'd3,      5'h0A, 3'd3, 3'd2, 3'd1, 15'h1A20, 1'b1, 2'd2};
    vecs[1] = '{19'b00001_111_000_101_10101, 16'd4,      5'h01, 3'd7, 3'd0, 3'd5, 15'h78B5, 1'b0, 2'd0};
    vecs[2] = '{19'b01011_000_111_010_11111, 16'd5,      5'h0B, 3'd0, 3'd7, 3'd2, 15'h475F, 1'b1, 2'd2};
    vecs[3] = '{19'b01100_101_110_011_00011, 16'hFFFF,   5'h0C, 3'd5, 3'd6, 3'd3, 15'h2E63, 1'b1, 2'd2};
    vecs[4] = '{19'b01101_000_000_000_00000, 16'd7,      5'h0D, 3'd0, 3'd0, 3'd0, 15'h4000, 1'b0, 2'd0};
    vecs[5] = '{19'b01001_111_111_111_11111, 16'h1234,   5'h09, 3'd7, 3'd7, 3'd7, 15'h7FFF, 1'b0, 2'd0};

    // Reset state.
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_opc", opcode, 0);
    check("rst_imm", immediate, 0);
    check("rst_pc", pc_out, 0);
    check("rst_pred", prediction, 0);
    check("rst_br", is_branch, 0);
    check("rst_ptaken", pred_taken, 0);

    // Table-driven decode, back to back with out_ready high.
    for (int i = 0; i < 6; i++) begin
      in_valid    = 1'b1;
      instruction = vecs[i].instr;
      pc          = vecs[i].pc;
      tick();
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end
    in_valid = 1'b0;
    tick();
    check("drain_valid", out_valid, 0);

    // Training on index 3: saturation at both ends.
    do_reset();
    upd_one(16'd3, 1'b0);
    upd_one(16'd3, 1'b0);
    fetch_one("train_nt2", BR_INSTR, 16'd3, 2'd0);
    for (int i = 0; i < 3; i++) upd_one(16'd3, 1'b0);
    fetch_one("train_sat0", BR_INSTR, 16'd3, 2'd0);
    for (int i = 0; i < 4; i++) upd_one(16'd3, 1'b1);
    fetch_one("train_t4", BR_INSTR, 16'd3, 2'd3);
    upd_one(16'd3, 1'b1);
    fetch_one("train_sat3", BR_INSTR, 16'd3, 2'd3);

    // Bypass with aliasing: pc 19 and pc 3 share index 3.
    do_reset();
    in_valid    = 1'b1;
    instruction = BR_INSTR;
    pc          = 16'd19;
    upd_valid   = 1'b1;
    upd_pc      = 16'd3;
    upd_taken   = 1'b0;
    tick();
    in_valid  = 1'b0;
    upd_valid = 1'b0;
    check("bypass_pred", prediction, 1);
    check("bypass_taken", pred_taken, 0);
    fetch_one("nonbr", NB_INSTR, 16'd3, 2'd0);
    check("nonbr_br", is_branch, 0);

    // Backpressure: three stall cycles in a stream of pc 0..7.
    do_reset();
    sent = 0;
    for (int cyc = 0; cyc < 40 && got.size() < 8; cyc++) begin
      in_valid    = (sent < 8);
      instruction = NB_INSTR;
      pc          = 16'(sent);
      out_ready   = !(cyc >= 3 && cyc <= 5);
      #1;
      if (out_valid && out_ready) got.push_back(int'(pc_out));
      if (cyc == 3) begin
        snap_pc  = pc_out;
        snap_opc = opcode;
        check("bp_held_pc", pc_out, 2);
      end
      if (cyc >= 3 && cyc <= 5) check($sformatf("bp_ready%0d", cyc), in_ready, 0);
      if (cyc >= 4 && cyc <= 6) begin
        check($sformatf("bp_stable_pc%0d", cyc), pc_out, snap_pc);
        check($sformatf("bp_stable_opc%0d", cyc), opcode, snap_opc);
        check($sformatf("bp_stable_v%0d", cyc), out_valid, 1);
      end
      hs = in_valid && in_ready;
      tick();
      if (hs) sent++;
    end
    check("bp_count", got.size(), 8);
    for (int i = 0; i < got.size(); i++) check($sformatf("bp_seq%0d", i), got[i], i);
    idle();

    // Flush: beats a coincident accept, and kills a stalled bundle.
    do_reset();
    upd_one(16'h0040, 1'b1);
    in_valid    = 1'b1;
    instruction = BR_INSTR;
    pc          = 16'h0040;
    flush       = 1'b1;
    #1;
    check("flush_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_valid", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("flush_gone%0d", i), out_valid, 0);
    end
    fetch_one("flush_bht", BR_INSTR, 16'h0040, 2'd3);
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    pc          = 16'h0021;
    tick();
    in_valid = 1'b0;
    check("flush_stall_v", out_valid, 1);
    flush = 1'b1;
    tick();
    flush     = 1'b0;
    out_ready = 1'b1;
    check("flush_stall_kill", out_valid, 0);

    // Mid-operation reset while stalled, with an update that must be lost.
    do_reset();
    upd_one(16'd5, 1'b0);
    upd_one(16'd5, 1'b0);
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    instruction = BR_INSTR;
    pc          = 16'd5;
    tick();
    in_valid = 1'b0;
    check("mrst_pre_pred", prediction, 0);
    tick();
    check("mrst_pre_valid", out_valid, 1);
    check("mrst_pre_ready", in_ready, 0);
    rst       = 1'b1;
    upd_valid = 1'b1;
    upd_pc    = 16'd5;
    upd_taken = 1'b1;
    tick();
    rst       = 1'b0;
    upd_valid = 1'b0;
    out_ready = 1'b1;
    check("mrst_valid", out_valid, 0);
    check("mrst_pc", pc_out, 0);
    for (int i = 0; i < 16; i++) fetch_one($sformatf("mrst_bht%0d", i), BR_INSTR, 16'(i), 2'd2);

    // Randomized run against a behavioural model.
    do_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 2;
    m_valid = 0;
    m_br = 0;
    m_opc = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_pc = 0; m_pred = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int ops [7];
      int op, k, ins_i;
      bit exp_ready, acc;
      ops = '{10, 11, 12, 1, 9, 13, 0};
      op = ops[$urandom_range(0, 6)];
      if (op == 0) op = int'($urandom_range(0, 31));
      ins_i       = (op << 14) | int'($urandom_range(0, 16383));
      instruction = 19'(ins_i);
      pc          = 16'($urandom);
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      upd_valid   = 1'($urandom_range(0, 1));
      upd_pc      = 16'($urandom_range(0, 40));
      upd_taken   = 1'($urandom_range(0, 1));
      #1;
      exp_ready = !m_valid || out_ready;
      check("rnd_ready", in_ready, exp_ready);
      check("rnd_valid", out_valid, m_valid);
      if (m_valid) begin
        check("rnd_opc", opcode, m_opc);
        check("rnd_rd", rd, m_rd);
        check("rnd_rs1", rs1, m_rs1);
        check("rnd_rs2", rs2, m_rs2);
        check("rnd_imm", immediate, m_imm);
        check("rnd_pc", pc_out, m_pc);
        check("rnd_br", is_branch, m_br);
        check("rnd_pred", prediction, m_pred);
        check("rnd_ptaken", pred_taken, m_br && (m_pred >= 2));
      end
      acc = in_valid && exp_ready && !flush;
      if (upd_valid) begin
        k = int'(upd_pc) % 16;
        if (upd_taken) m_bht[k] = (m_bht[k] + 1 > 3) ? 3 : m_bht[k] + 1;
        else           m_bht[k] = (m_bht[k] - 1 < 0) ? 0 : m_bht[k] - 1;
      end
      if (flush) begin
        m_valid = 0;
      end else if (acc) begin
        m_valid = 1;
        m_opc   = ins_i / 16384;
        m_rd    = (ins_i / 2048) % 8;
        m_rs1   = (ins_i / 256) % 8;
        m_rs2   = (ins_i / 32) % 8;
        m_imm   = ins_i % 32768;
        m_pc    = int'(pc);
        m_br    = (m_opc >= 10 && m_opc <= 12);
        m_pred  = m_br ? m_bht[int'(pc) % 16] : 0;
      end else if (out_ready) begin
        m_valid = 0;
      end
      tick();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
